clock_div: RTL and testbench
============================

CLOCK_DIV -- requirements
Module: clock_div

Interface
REQ-001 The block SHALL expose parameter INPUT_CLOCK_FLUENCY, default 100_000_000, meaning input clock frequency in Hz.
REQ-002 The block SHALL expose parameter OUTPUT_CLOCK_FLUENCY, default 1_000_000, meaning desired output clock frequency in Hz.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 clk_div  output  1  divided clock, driven directly from a register.

Function
REQ-006 The block SHALL compute the elaboration-time constant HALF = INPUT_CLOCK_FLUENCY / (2 * OUTPUT_CLOCK_FLUENCY), using integer division with truncation.
REQ-007 If HALF evaluates to 0, the block SHALL clamp it to 1, giving a toggle every input cycle.
REQ-008 The internal counter width SHALL be clog2(HALF), with a minimum of 1 bit; the counter SHALL never exceed HALF-1.
REQ-009 On each rising clk edge with rst low, if counter == HALF-1, the counter SHALL load 0 and clk_div SHALL invert; otherwise the counter SHALL increment by 1 and clk_div SHALL hold.
REQ-010 Output period SHALL be exactly 2*HALF input cycles, high for HALF cycles and low for HALF cycles (50% duty).
REQ-011 When INPUT/OUTPUT is not an even integer, the output frequency SHALL be INPUT/(2*HALF), which is at or above the requested value; no fractional correction is applied.
REQ-012 After reset release, the first rising edge of clk_div SHALL occur on the HALF-th rising clk edge with rst low.
REQ-013 clk_div SHALL be glitch-free: it changes only on rising clk edges and has no combinational path from any input.
REQ-014 Multiple instances with different parameters SHALL operate independently from a shared clk/rst.

Reset
REQ-015 While rst is high at a rising clk edge, the counter SHALL load 0 and clk_div SHALL load 0.
REQ-016 Assertion of rst mid-period SHALL abort the current half-period; counting SHALL restart from 0 on the first edge with rst low.
REQ-017 Before the first clk edge with rst high, outputs are undefined; the bench SHALL apply reset for at least one clk edge.

Verification
REQ-018 100 MHz clk (10 ns period), OUTPUT=50_000_000 (HALF=1), rst high for 1 edge then low -> clk_div toggles every edge: 0,1,0,1...; period 20 ns.
REQ-019 Same clk, OUTPUT=10_000_000 (HALF=5) -> clk_div low for 5 edges after release, then high for 5 and low for 5; period 100 ns, duty 50%.
REQ-020 Both instances from REQ-018 and REQ-019 on a shared clk/rst -> each matches its own expected waveform, and every 5th edge of the ÷2 output coincides with an edge of the ÷10 output.
REQ-021 OUTPUT=30_000_000 (HALF=1 by truncation) -> same waveform as REQ-018; OUTPUT=200_000_000 (HALF=0, clamped) -> also toggles every edge.
REQ-022 HALF=5, rst reasserted for 1 edge when counter=3 with clk_div=1 -> clk_div=0 and counter=0 after that edge; the next rise occurs 5 edges after release.
REQ-023 Default parameters (HALF=50) -> clk_div period 100 input cycles; counter observed 0..49 only.

Source files
------------

// File: rtl/clock_div.sv
// Parameterised clock divider: produces a 50% duty clock at
// INPUT_CLOCK_FLUENCY / (2*HALF), driven straight from a flop so the
// output can never glitch.
module clock_div #(
   parameter int unsigned INPUT_CLOCK_FLUENCY  = 100_000_000,
   parameter int unsigned OUTPUT_CLOCK_FLUENCY = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   output logic clk_div
);

   // Input cycles per output half-period, truncated. A requested output
   // faster than half the input clock truncates to 0, which is clamped to 1
   // so the divider degrades to a toggle on every input edge.
   localparam int unsigned HALF_RAW = INPUT_CLOCK_FLUENCY / (2 * OUTPUT_CLOCK_FLUENCY);
   localparam int unsigned HALF     = (HALF_RAW == 0) ? 1 : HALF_RAW;

   // Counter only needs to reach HALF-1; keep at least one bit so the
   // declaration stays legal when HALF is 1.
   localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

   logic [CNT_W-1:0] count;

   // Count input edges through one half-period, then wrap and flip the output.
   always_ff @(posedge clk) begin
      if (rst) begin
         count   <= '0;
         clk_div <= 1'b0;
      end else if (count == LAST) begin
         count   <= '0;
         clk_div <= ~clk_div;
      end else begin
         count   <= count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_clock_div.sv
// Self-checking bench for clock_div: several instances with different
// ratios share one clk/rst, and each output is compared every cycle against
// a reference model that derives the waveform from the count of edges
// since reset release.
`timescale 1ns/1ps
module tb_clock_div;

   localparam longint IN_HZ = 100_000_000;

   logic clk;
   logic rst;
   logic divA, divB, divC, divD, divE, divF, divG;

   int vectors    = 0;
   int miscompares = 0;
   int cycle      = 0;
   int sinceRel   = 0;

   // Instances: /2, /10, /2 by truncation, /2 by clamping, default /100,
   // /8, and an uneven request that truncates to HALF=7.
   clock_div #(.INPUT_CLOCK_FLUENCY(100_000_000), .OUTPUT_CLOCK_FLUENCY(50_000_000))
      uA (.clk(clk), .rst(rst), .clk_div(divA));
   clock_div #(.INPUT_CLOCK_FLUENCY(100_000_000), .OUTPUT_CLOCK_FLUENCY(10_000_000))
      uB (.clk(clk), .rst(rst), .clk_div(divB));
   clock_div #(.INPUT_CLOCK_FLUENCY(100_000_000), .OUTPUT_CLOCK_FLUENCY(30_000_000))
      uC (.clk(clk), .rst(rst), .clk_div(divC));
   clock_div #(.INPUT_CLOCK_FLUENCY(100_000_000), .OUTPUT_CLOCK_FLUENCY(200_000_000))
      uD (.clk(clk), .rst(rst), .clk_div(divD));
   clock_div
      uE (.clk(clk), .rst(rst), .clk_div(divE));
   clock_div #(.INPUT_CLOCK_FLUENCY(100_000_000), .OUTPUT_CLOCK_FLUENCY(12_500_000))
      uF (.clk(clk), .rst(rst), .clk_div(divF));
   clock_div #(.INPUT_CLOCK_FLUENCY(100_000_000), .OUTPUT_CLOCK_FLUENCY(7_000_000))
      uG (.clk(clk), .rst(rst), .clk_div(divG));

   // 100 MHz input clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Half-period length in input cycles, computed straight from the ratio.
   function automatic int halfOf(longint outHz);
      longint h;
      h = IN_HZ / (2 * outHz);
      if (h == 0) h = 1;
      return int'(h);
   endfunction

   // Output level after n edges since release: low for the first HALF edges,
   // then alternating blocks of HALF edges.
   function automatic logic expectedDiv(int n, int h);
      return logic'(((n / h) % 2) == 1);
   endfunction

   task automatic checkOutput(input string tag, input logic actual, input logic expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got %b expected %b (cycle %0d, edges since release %0d)",
                  tag, actual, expected, cycle, sinceRel);
      end
   endtask

   // Drive rst for one input edge, advance the model, then compare all
   // outputs on the following falling edge.
   task automatic applyStimulus(input logic r);
      rst = r;
      @(posedge clk);
      cycle++;
      if (r) sinceRel = 0;
      else   sinceRel++;
      @(negedge clk);
      checkOutput("div2",       divA, expectedDiv(sinceRel, halfOf(50_000_000)));
      checkOutput("div10",      divB, expectedDiv(sinceRel, halfOf(10_000_000)));
      checkOutput("div2_trunc", divC, expectedDiv(sinceRel, halfOf(30_000_000)));
      checkOutput("div2_clamp", divD, expectedDiv(sinceRel, halfOf(200_000_000)));
      checkOutput("div100",     divE, expectedDiv(sinceRel, halfOf(1_000_000)));
      checkOutput("div8",       divF, expectedDiv(sinceRel, halfOf(12_500_000)));
      checkOutput("div14",      divG, expectedDiv(sinceRel, halfOf(7_000_000)));
   endtask

   // Directed reset/free-run/mid-period reset, then randomized reset pulses.
   initial begin
      rst = 1'b1;
      @(negedge clk);
      applyStimulus(1'b1);
      applyStimulus(1'b1);

      // Free run long enough to cover a full /100 period and then some.
      for (int i = 0; i < 230; i++) applyStimulus(1'b0);

      // Reset once the /10 output is high with its count at 3 (8 edges in).
      applyStimulus(1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0);
      applyStimulus(1'b1);
      for (int i = 0; i < 30; i++) applyStimulus(1'b0);

      // Random operation with occasional 1-3 edge reset pulses.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 59) == 0) begin
            int len;
            len = int'($urandom_range(1, 3));
            for (int k = 0; k < len; k++) applyStimulus(1'b1);
         end else begin
            applyStimulus(1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
